// File: rtl/mem_ctrl.sv
// mem_ctrl: load/store access controller between MEM and the data bus.
// Drives a req/ack bus, stalls the pipeline, returns extended load data.
module mem_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_sext_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_req_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        adel_q, adel_d;
    logic        ades_q, ades_d;
    logic        err_q, err_d;

    logic        misal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Alignment check, byte enables and lane-replicated store data
    always_comb begin
        misal     = 1'b0;
        be_new    = 4'b1111;
        wdata_new = mem_wdata_i;
        unique case (mem_size_i)
            2'b00: begin
                be_new    = 4'b0001 << mem_addr_i[1:0];
                wdata_new = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                misal     = mem_addr_i[0];
                be_new    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                misal = (mem_addr_i[1:0] != 2'b00);
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned read word
    always_comb begin
        unique case (off_q)
            2'd0:    ld_byte = bus_rdata_i[7:0];
            2'd1:    ld_byte = bus_rdata_i[15:8];
            2'd2:    ld_byte = bus_rdata_i[23:16];
            default: ld_byte = bus_rdata_i[31:24];
        endcase
        ld_half = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        unique case (size_q)
            2'b00:   ld_ext = {{24{sext_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{sext_q & ld_half[15]}}, ld_half};
            default: ld_ext = bus_rdata_i;
        endcase
    end

    // Next-state logic and latching of the access attributes
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sext_d  = sext_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        adel_d  = 1'b0;
        ades_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_en_i) begin
                    if (misal) begin
                        state_d = DONE;
                        adel_d  = ~mem_we_i;
                        ades_d  = mem_we_i;
                        rdata_d = '0;
                    end else begin
                        state_d = REQ;
                        addr_d  = {mem_addr_i[31:2], 2'b00};
                        we_d    = mem_we_i;
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        size_d  = mem_size_i;
                        sext_d  = mem_sext_i;
                        off_d   = mem_addr_i[1:0];
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                if (bus_ack_i) begin
                    state_d = DONE;
                    rdata_d = we_q ? 32'd0 : ld_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            off_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            adel_q  <= adel_d;
            ades_q  <= ades_d;
            err_q   <= err_d;
        end
    end

    // Stall is combinational so a new access freezes in its arrival cycle
    assign stall_req_o = rst & ((mem_en_i & (state_q == IDLE))
                                | (state_q == REQ));
    assign bus_req_o   = (state_q == REQ);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign done_o      = (state_q == DONE);
    assign rdata_o     = rdata_q;
    assign adel_o      = adel_q;
    assign ades_o      = ades_q;
    assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl bus handshake, stall,
// lane handling, alignment errors, timeout and async reset.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic        mem_sext_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stall_req_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        adel_o;
    logic        ades_o;
    logic        bus_err_o;

    int n_cmp = 0;
    int n_err = 0;

    int          r_req, r_stall, r_done;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic        r_we, r_adel, r_ades, r_err;

    mem_ctrl #(.TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_en_i    (mem_en_i),
        .mem_we_i    (mem_we_i),
        .mem_size_i  (mem_size_i),
        .mem_sext_i  (mem_sext_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .stall_req_o (stall_req_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .adel_o      (adel_o),
        .ades_o      (ades_o),
        .bus_err_o   (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One access; waits < 0 means the ack never comes
    task automatic access(input logic we, input logic [1:0] size,
                          input logic sext, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits,
                          input logic [31:0] rword);
        r_req = 0; r_stall = 0; r_done = 0;
        r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
        r_rdata = '0; r_adel = 1'b0; r_ades = 1'b0; r_err = 1'b0;
        @(negedge clk);
        mem_en_i    = 1'b1;
        mem_we_i    = we;
        mem_size_i  = size;
        mem_sext_i  = sext;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (stall_req_o) r_stall++;
            if (done_o) begin
                r_done  = 1;
                r_rdata = rdata_o;
                r_adel  = adel_o;
                r_ades  = ades_o;
                r_err   = bus_err_o;
                mem_en_i  = 1'b0;
                bus_ack_i = 1'b0;
                break;
            end
            if (bus_req_o) begin
                r_req++;
                r_addr  = bus_addr_o;
                r_be    = bus_be_o;
                r_wdata = bus_wdata_o;
                r_we    = bus_we_o;
                if (waits >= 0 && r_req > waits) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = rword;
                end else begin
                    bus_ack_i = 1'b0;
                end
            end
            @(negedge clk);
        end
        mem_en_i  = 1'b0;
        bus_ack_i = 1'b0;
        check("done_within_bound", 32'(r_done), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        mem_en_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00;
        mem_sext_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        repeat (2) @(negedge clk);
        mem_en_i = 1'b1;
        #1;
        check("rst_stall", 32'(stall_req_o), 32'd0);
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_addr", bus_addr_o, 32'd0);
        check("rst_be", 32'(bus_be_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_flags",
              {28'd0, bus_we_o, adel_o, ades_o, bus_err_o}, 32'd0);
        mem_en_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // lw, 3 wait cycles
        access(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0, 3, 32'hDEADBEEF);
        check("lw_addr", r_addr, 32'h0000_1004);
        check("lw_be", 32'(r_be), 32'hF);
        check("lw_req_cycles", 32'(r_req), 32'd4);
        check("lw_stall_cycles", 32'(r_stall), 32'd5);
        check("lw_rdata", r_rdata, 32'hDEADBEEF);

        // lb / lbu on lane 3
        access(1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 0, 32'h80FF_1234);
        check("lb_addr", r_addr, 32'h0000_2000);
        check("lb_be", 32'(r_be), 32'h8);
        check("lb_stall", 32'(r_stall), 32'd2);
        check("lb_rdata", r_rdata, 32'hFFFF_FF80);
        access(1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0, 0, 32'h80FF_1234);
        check("lbu_be", 32'(r_be), 32'h8);
        check("lbu_rdata", r_rdata, 32'h0000_0080);

        // lh / lhu on the upper half, byte on lane 1
        access(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 1, 32'h80FF_1234);
        check("lh_be", 32'(r_be), 32'hC);
        check("lh_rdata", r_rdata, 32'hFFFF_80FF);
        access(1'b0, 2'b01, 1'b0, 32'h0000_2000, 32'h0, 0, 32'h80FF_9234);
        check("lhu_be", 32'(r_be), 32'h3);
        check("lhu_rdata", r_rdata, 32'h0000_9234);
        access(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0, 0, 32'h80FF_1234);
        check("lb1_be", 32'(r_be), 32'h2);
        check("lb1_rdata", r_rdata, 32'h0000_0012);

        // sh, sb
        access(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 0, 32'h0);
        check("sh_we", 32'(r_we), 32'd1);
        check("sh_be", 32'(r_be), 32'hC);
        check("sh_wdata", r_wdata, 32'hABCD_ABCD);
        check("sh_rdata", r_rdata, 32'd0);
        access(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56A5, 0, 32'h0);
        check("sb_be", 32'(r_be), 32'h2);
        check("sb_wdata", r_wdata, 32'hA5A5_A5A5);

        // misaligned lw / sw / lh
        access(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 0, 32'h0);
        check("adel_req", 32'(r_req), 32'd0);
        check("adel_stall", 32'(r_stall), 32'd1);
        check("adel_flags", {29'd0, r_adel, r_ades, r_err}, 32'h4);
        check("adel_rdata", r_rdata, 32'd0);
        access(1'b1, 2'b10, 1'b0, 32'h0000_4001, 32'h5555_5555, 0, 32'h0);
        check("ades_req", 32'(r_req), 32'd0);
        check("ades_flags", {29'd0, r_adel, r_ades, r_err}, 32'h2);
        access(1'b0, 2'b01, 1'b0, 32'h0000_4003, 32'h0, 0, 32'h0);
        check("lh_misal_flags", {29'd0, r_adel, r_ades, r_err}, 32'h4);

        // timeout: a load first so rdata_o is nonzero beforehand
        access(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 0, 32'h1111_2222);
        access(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, -1, 32'h0);
        check("to_req_cycles", 32'(r_req), 32'd15);
        check("to_stall_cycles", 32'(r_stall), 32'd16);
        check("to_flags", {29'd0, r_adel, r_ades, r_err}, 32'h1);
        check("to_rdata", r_rdata, 32'd0);

        // async reset in the second REQ cycle
        @(negedge clk);
        mem_en_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b10;
        mem_addr_i = 32'h0000_7000;
        @(negedge clk);
        #1;
        check("pre_rst_req", 32'(bus_req_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus_req_o), 32'd0);
        check("mid_rst_stall", 32'(stall_req_o), 32'd0);
        mem_en_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        r_done = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (done_o || bus_req_o) r_done++;
        end
        bus_ack_i = 1'b0;
        check("late_ack_ignored", 32'(r_done), 32'd0);
        check("late_ack_stall", 32'(stall_req_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Load/store access controller between the MEM pipeline stage and the data-memory bus. Takes one load or store per instruction from MEM and drives a req/ack bus with word address, byte enables and lane-replicated write data. Freezes the pipeline via `stall_req_o` until the access completes, then returns the aligned, extended load result. Also flags misaligned addresses and bus timeouts.

## Interface
- `TIMEOUT`, 15: REQ-state cycles without `bus_ack_i` before the access is aborted; range 1..255.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `mem_en_i`  in  1  MEM stage holds a load/store this cycle.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_size_i`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `mem_sext_i`  in  1  sign-extend a byte/half load (lb/lh); 0 = zero-extend (lbu/lhu).
- `mem_addr_i`  in  32  byte address.
- `mem_wdata_i`  in  32  store data, right-aligned.
- `bus_req_o`  out  1  bus request.
- `bus_we_o`  out  1  bus write.
- `bus_addr_o`  out  32  word address, bits [1:0] = 00.
- `bus_be_o`  out  4  byte enables; bit n = byte lane n.
- `bus_wdata_o`  out  32  lane-replicated store data.
- `bus_ack_i`  in  1  access complete; `bus_rdata_i` valid in the same cycle.
- `bus_rdata_i`  in  32  read word.
- `stall_req_o`  out  1  freeze IF..MEM this cycle.
- `done_o`  out  1  one-cycle pulse: access finished (ok or error).
- `rdata_o`  out  32  extended load result; valid while `done_o`=1.
- `adel_o` / `ades_o`  out  1  address error on load / store; pulses with `done_o`.
- `bus_err_o`  out  1  timeout; pulses with `done_o`.

## Operation
- FSM states: IDLE, REQ, DONE.
- Little-endian lane mapping: lane = addr[1:0].
- Alignment rules: half needs addr[0]=0; word needs addr[1:0]=00.
- IDLE, `mem_en_i`=1, aligned -> REQ. Latch `bus_addr_o` = {addr[31:2],2'b00}, `bus_we_o`, `bus_be_o`, `bus_wdata_o`, size, sext and addr[1:0]. Clear the timeout counter.
- IDLE, `mem_en_i`=1, misaligned -> DONE with `adel_o`/`ades_o` set. No bus request is made.
- Byte enables: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
- Write data: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
- REQ: `bus_req_o`=1, all bus outputs held stable.
  - `bus_ack_i`=1 -> DONE. For a load, capture the lane-selected byte/half/word into `rdata_o`, extended per `mem_sext_i`.
  - Counter reaches `TIMEOUT` without ack -> DONE with `bus_err_o`=1 and `rdata_o`=0.
- DONE: `done_o`=1, `stall_req_o`=0, so the pipeline advances at this edge. Then -> IDLE unconditionally.
- `rdata_o` is 0 after a store or any error.
- `stall_req_o` = `mem_en_i` & (state==IDLE) | (state==REQ). Purely combinational, so the instruction freezes in the same cycle it arrives. A misaligned access stalls exactly 1 cycle.
- Async reset (`rst`=0) mid-access: return to IDLE immediately and drop `bus_req_o` without waiting for ack. A late ack arriving in IDLE is ignored.

## Timing
- Reset values:
  - `bus_req_o`, `bus_we_o`, `done_o`, `adel_o`, `ades_o`, `bus_err_o` = 0.
  - `bus_addr_o`, `bus_wdata_o`, `rdata_o` = 0; `bus_be_o` = 0000.
  - `stall_req_o` = 0 while `rst`=0.
- Aligned access, ack in the first REQ cycle:
  - cycle 0: IDLE, stall=1.
  - cycle 1: REQ, req=1, ack=1, stall=1.
  - cycle 2: DONE, `done_o`=1.
  - Total: 2 stall cycles.
- Each extra wait cycle before ack adds 1 stall cycle.
- Timeout: DONE follows the TIMEOUT-th REQ cycle, so `bus_req_o` is high for exactly TIMEOUT cycles.
- Back-to-back accesses: the next instruction is seen in IDLE the cycle after DONE. `bus_req_o` is low for at least 2 cycles between accesses.
- `mem_en_i` is sampled only in IDLE. Changes during REQ/DONE are ignored.

## Test plan
- lw, addr 0x0000_1004, ack after 3 wait cycles, rdata 0xDEADBEEF:
  - bus_addr 0x1004, be 1111, req high 4 cycles, stall 5 cycles.
  - `done_o` with rdata_o 0xDEADBEEF.
- lb at 0x0000_2003 (sext=1) and lbu at the same address (sext=0), bus_rdata 0x80FF_1234:
  - be 1000 for both.
  - rdata_o 0xFFFFFF80 (lb), then 0x00000080 (lbu).
- sh at 0x0000_3002, wdata 0x0000_ABCD, immediate ack:
  - bus_we=1, be 1100, bus_wdata 0xABCDABCD.
  - `done_o` with rdata_o 0.
- lw at 0x0000_4002:
  - no bus_req, 1-cycle stall, `adel_o`=`done_o`=1.
- sw at 0x0000_4001:
  - `ades_o`=1, no bus_req.
- Ack never arrives, TIMEOUT=15:
  - req high exactly 15 cycles, then `bus_err_o`=`done_o`=1, rdata_o 0.
- rst pulled low during cycle 2 of REQ:
  - `bus_req_o`=0 and `stall_req_o`=0 immediately, FSM in IDLE.
  - Ack asserted after reset release while `mem_en_i`=0 is ignored: no `done_o`.
